// File: rtl/alu_op_sequencer.sv
// Sequences 8/16-bit commands onto an 8-bit combinational ALU, one byte per cycle, and merges the per-byte results.
// Optional build macro ALU_SEQ_OPCNT_EN adds the op_count response-handshake counter port.
`timescale 1ns/1ps

// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// LO    | low-byte operands on the ALU
// HI    | high-byte operands on the ALU (wide commands only)
// RESP  | response held until rsp_ready
module alu_op_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_op,
    input  logic        cmd_wide,
    input  logic [15:0] cmd_a,
    input  logic [15:0] cmd_b,
    input  logic        cmd_cin,
    output logic [7:0]  alu_x,
    output logic [7:0]  alu_y,
    output logic [3:0]  alu_opcode,
    output logic        alu_cin,
    input  logic [7:0]  alu_z,
    input  logic        alu_cout,
    input  logic        alu_xby,
    input  logic        alu_ybx,
    input  logic        alu_xey,
`ifdef ALU_SEQ_OPCNT_EN
    output logic [15:0] op_count,
`endif
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic        rsp_cout,
    output logic        rsp_agb,
    output logic        rsp_bga,
    output logic        rsp_aeb
);

    typedef enum logic [1:0] {IDLE, LO, HI, RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  op_q;
    logic        wide_q;
    logic [7:0]  a_hi_q;
    logic        a7_q;
    logic [7:0]  b_hi_q;
    logic [7:0]  z_lo_q;
    logic        agb_lo_q, bga_lo_q, aeb_lo_q;

    logic        accept, done, rsp_fire;
    logic [7:0]  lo_z, byte_hi;
    logic        lo_agb, lo_bga, lo_aeb, use_hi;
    logic        m_agb, m_bga, m_aeb, m_flag;
    logic [15:0] m_data;
    logic        m_cout;

    assign cmd_ready = (state_q == IDLE);
    assign accept    = cmd_valid & cmd_ready;
    assign done      = ((state_q == LO) & ~wide_q) | (state_q == HI);
    assign rsp_fire  = rsp_valid & rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_valid) state_d = LO;
            LO:      state_d = wide_q ? HI : RESP;
            HI:      state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Low-byte values come live from the ALU in LO, from the capture registers in HI.
    always_comb begin
        lo_z    = (state_q == HI) ? z_lo_q   : alu_z;
        lo_agb  = (state_q == HI) ? agb_lo_q : alu_xby;
        lo_bga  = (state_q == HI) ? bga_lo_q : alu_ybx;
        lo_aeb  = (state_q == HI) ? aeb_lo_q : alu_xey;
        use_hi  = wide_q & ~alu_xey;
        m_agb   = use_hi ? alu_xby : lo_agb;
        m_bga   = use_hi ? alu_ybx : lo_bga;
        m_aeb   = use_hi ? alu_xey : lo_aeb;
        byte_hi = wide_q ? alu_z : 8'h00;
        m_flag  = 1'b0;
        m_data  = 16'h0000;
        m_cout  = 1'b0;
        case (op_q)
            4'd0: begin
                m_data = {byte_hi, lo_z};
                // alu_cout is the last byte's carry in whichever state finishes the command
                m_cout = alu_cout;
            end
            4'd1, 4'd2, 4'd3: m_data = {byte_hi, lo_z};
            4'd4: m_data = wide_q ? {alu_z[7:1], a7_q, lo_z} : {8'h00, lo_z};
            4'd5: m_data = wide_q ? {alu_z, a_hi_q[0], lo_z[6:0]} : {8'h00, lo_z};
            4'd6, 4'd7, 4'd8: begin
                m_flag = (op_q == 4'd6) ? m_agb : (op_q == 4'd7) ? m_bga : m_aeb;
                m_data = {(wide_q ? {8{m_flag}} : 8'h00), {8{m_flag}}};
            end
            default: m_data = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q       <= 4'd0;
            wide_q     <= 1'b0;
            a_hi_q     <= 8'h00;
            a7_q       <= 1'b0;
            b_hi_q     <= 8'h00;
            z_lo_q     <= 8'h00;
            agb_lo_q   <= 1'b0;
            bga_lo_q   <= 1'b0;
            aeb_lo_q   <= 1'b0;
            alu_x      <= 8'h00;
            alu_y      <= 8'h00;
            alu_opcode <= 4'd0;
            alu_cin    <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_data   <= 16'h0000;
            rsp_cout   <= 1'b0;
            rsp_agb    <= 1'b0;
            rsp_bga    <= 1'b0;
            rsp_aeb    <= 1'b0;
        end else begin
            if (accept) begin
                op_q       <= cmd_op;
                wide_q     <= cmd_wide;
                a_hi_q     <= cmd_a[15:8];
                a7_q       <= cmd_a[7];
                b_hi_q     <= cmd_b[15:8];
                alu_x      <= cmd_a[7:0];
                alu_y      <= cmd_b[7:0];
                alu_opcode <= cmd_op;
                alu_cin    <= cmd_cin;
            end
            if (state_q == LO) begin
                z_lo_q   <= alu_z;
                agb_lo_q <= alu_xby;
                bga_lo_q <= alu_ybx;
                aeb_lo_q <= alu_xey;
                if (wide_q) begin
                    alu_x   <= a_hi_q;
                    alu_y   <= b_hi_q;
                    alu_cin <= alu_cout;
                end
            end
            if (done) begin
                rsp_valid <= 1'b1;
                rsp_data  <= m_data;
                rsp_cout  <= m_cout;
                rsp_agb   <= m_agb;
                rsp_bga   <= m_bga;
                rsp_aeb   <= m_aeb;
            end else if (rsp_fire) begin
                rsp_valid <= 1'b0;
            end
        end
    end

`ifdef ALU_SEQ_OPCNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        op_count <= 16'h0000;
        else if (rsp_fire) op_count <= op_count + 16'd1;
    end
`endif

endmodule
